// File: rtl/bomba_pkg.sv
// Shared types for the bomb countdown timer: FSM states, BCD digits and the MM:SS record.
// Used by temporizador_bomba and decremento_mmss.
package bomba_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMADO    = 3'd1,
    PAUSADO   = 3'd2,
    EXPLODIU  = 3'd3,
    DESARMADO = 3'd4
  } estado_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_d;
    bcd_t min_u;
    bcd_t sec_d;
    bcd_t sec_u;
  } mmss_t;

  // Minutes may go up to 99; seconds tens digit must stay within 0..5.
  function automatic logic bcd_valido(logic [7:0] preset_min, logic [7:0] preset_sec);
    return (preset_min[7:4] <= 4'd9) && (preset_min[3:0] <= 4'd9) &&
           (preset_sec[7:4] <= 4'd5) && (preset_sec[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/decremento_mmss.sv
// Combinational one-second decrement of an MM:SS BCD value with borrow chain.
// Saturates at 00:00; zero_o flags that the result is 00:00.
module decremento_mmss
  import bomba_pkg::*;
(
  input  mmss_t atual_i,
  output mmss_t proximo_o,
  output logic  zero_o
);

  always_comb begin
    proximo_o = atual_i;
    if (atual_i != '0) begin
      if (atual_i.sec_u != 4'd0) begin
        proximo_o.sec_u = atual_i.sec_u - 4'd1;
      end else begin
        proximo_o.sec_u = 4'd9;
        if (atual_i.sec_d != 4'd0) begin
          proximo_o.sec_d = atual_i.sec_d - 4'd1;
        end else begin
          proximo_o.sec_d = 4'd5;
          if (atual_i.min_u != 4'd0) begin
            proximo_o.min_u = atual_i.min_u - 4'd1;
          end else begin
            // Input is nonzero with all lower digits zero, so min_d is at least 1 here.
            proximo_o.min_u = 4'd9;
            proximo_o.min_d = atual_i.min_d - 4'd1;
          end
        end
      end
    end
  end

  assign zero_o = (proximo_o == '0);

endmodule

// File: rtl/temporizador_bomba.sv
// Bomb countdown timer: MM:SS BCD count driven by a 1 Hz tick, with arm/pause/defuse FSM.
// Optional blinking alert output enabled by defining BOMBA_ALERTA_EN.
module temporizador_bomba
  import bomba_pkg::*;
#(
  parameter logic [7:0] INIT_MIN = 8'h05,
  parameter logic [7:0] INIT_SEC = 8'h00
`ifdef BOMBA_ALERTA_EN
  , parameter int ALERT_SECS = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       desarmar,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] sec_d,
  output logic [3:0] sec_u,
  output logic       armado,
  output logic       explodiu,
  output logic       desarmado,
  output logic       erro_preset
`ifdef BOMBA_ALERTA_EN
  , output logic     alerta
`endif
);

  estado_t state_q, state_d;
  mmss_t   digits_q, digits_d;
  mmss_t   preset, dec;
  logic    dec_zero;
  logic    preset_ok;
  logic    at_zero;
  logic    erro_q, erro_d;
  logic    armado_q, explodiu_q, desarmado_q;

  assign preset    = {preset_min, preset_sec};
  assign preset_ok = bcd_valido(preset_min, preset_sec);
  assign at_zero   = (digits_q == '0);

  decremento_mmss u_decremento (
    .atual_i   (digits_q),
    .proximo_o (dec),
    .zero_o    (dec_zero)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    erro_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (preset_ok) digits_d = preset;
          else           erro_d   = 1'b1;
        end else if (start && !at_zero) begin
          state_d = ARMADO;
        end
      end
      ARMADO: begin
        if (desarmar) begin
          state_d = DESARMADO;
        end else if (pause) begin
          state_d = PAUSADO;
        end else if (tick_1s) begin
          digits_d = dec;
          if (dec_zero) state_d = EXPLODIU;
        end
      end
      PAUSADO: begin
        if (desarmar)   state_d = DESARMADO;
        else if (start) state_d = ARMADO;
      end
      EXPLODIU, DESARMADO: begin
        if (load) begin
          if (preset_ok) begin
            digits_d = preset;
            state_d  = IDLE;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      digits_q    <= mmss_t'({INIT_MIN, INIT_SEC});
      erro_q      <= 1'b0;
      armado_q    <= 1'b0;
      explodiu_q  <= 1'b0;
      desarmado_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      erro_q      <= erro_d;
      armado_q    <= (state_d == ARMADO);
      explodiu_q  <= (state_d == EXPLODIU);
      desarmado_q <= (state_d == DESARMADO);
    end
  end

  assign min_d       = digits_q.min_d;
  assign min_u       = digits_q.min_u;
  assign sec_d       = digits_q.sec_d;
  assign sec_u       = digits_q.sec_u;
  assign armado      = armado_q;
  assign explodiu    = explodiu_q;
  assign desarmado   = desarmado_q;
  assign erro_preset = erro_q;

`ifdef BOMBA_ALERTA_EN
  logic       alerta_q, alerta_d;
  logic [6:0] seg_rest;
  logic       em_janela;

  assign seg_rest  = ({3'b000, digits_q.sec_d} * 7'd10) + {3'b000, digits_q.sec_u};
  assign em_janela = (digits_q.min_d == 4'd0) && (digits_q.min_u == 4'd0) &&
                     (seg_rest <= 7'(ALERT_SECS));

  // The window is judged on the time before the tick, so the blink starts one tick in.
  always_comb begin
    alerta_d = 1'b0;
    if (state_d == EXPLODIU) begin
      alerta_d = 1'b1;
    end else if ((state_q == ARMADO) && (state_d == ARMADO)) begin
      if (tick_1s) alerta_d = em_janela ? ~alerta_q : 1'b0;
      else         alerta_d = alerta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) alerta_q <= 1'b0;
    else       alerta_q <= alerta_d;
  end

  assign alerta = alerta_q;
`endif

endmodule

// File: tb/tb_temporizador_bomba.sv
// Directed, table-driven bench for temporizador_bomba; the alert sequence runs when
// BOMBA_ALERTA_EN is defined.
module tb_temporizador_bomba;

  typedef struct {
    logic        tick;
    logic        load;
    logic        start;
    logic        pause;
    logic        des;
    logic [7:0]  pmin;
    logic [7:0]  psec;
    logic [15:0] expDig;
    logic [3:0]  expFlags;
  } vec_t;

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] A = 4'b1000;
  localparam logic [3:0] E = 4'b0100;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] R = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1s = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       desarmar = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [3:0] min_d, min_u, sec_d, sec_u;
  logic       armado, explodiu, desarmado, erro_preset;
`ifdef BOMBA_ALERTA_EN
  logic       alerta;
`endif

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

`ifdef BOMBA_ALERTA_EN
  temporizador_bomba #(.ALERT_SECS(3)) dut (
`else
  temporizador_bomba dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .tick_1s     (tick_1s),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .desarmar    (desarmar),
    .preset_min  (preset_min),
    .preset_sec  (preset_sec),
    .min_d       (min_d),
    .min_u       (min_u),
    .sec_d       (sec_d),
    .sec_u       (sec_u),
    .armado      (armado),
    .explodiu    (explodiu),
    .desarmado   (desarmado),
    .erro_preset (erro_preset)
`ifdef BOMBA_ALERTA_EN
    , .alerta    (alerta)
`endif
  );

  function automatic vec_t mkVec(logic t, logic l, logic s, logic p, logic d,
                                 logic [7:0] pm, logic [7:0] ps,
                                 logic [15:0] dig, logic [3:0] fl);
    vec_t v;
    v.tick = t; v.load = l; v.start = s; v.pause = p; v.des = d;
    v.pmin = pm; v.psec = ps; v.expDig = dig; v.expFlags = fl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkState(input string name, input logic [15:0] dig, input logic [3:0] fl);
    checkOutput({name, " digits"}, {16'h0, min_d, min_u, sec_d, sec_u}, {16'h0, dig});
    checkOutput({name, " flags"}, {28'h0, armado, explodiu, desarmado, erro_preset}, {28'h0, fl});
  endtask

  // One cycle of stimulus: drive on the falling edge, sample just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    tick_1s = v.tick; load = v.load; start = v.start; pause = v.pause; desarmar = v.des;
    preset_min = v.pmin; preset_sec = v.psec;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    tick_1s = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; desarmar = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Countdown to explosion, borrow chains, pause/defuse priority, load rules.
    vecs.push_back(mkVec(0,0,0,0,0, 8'h00,8'h00, 16'h0500, N));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h03, 16'h0003, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0003, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0002, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0001, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0000, E));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0000, E));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h10,8'h00, 16'h1000, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h1000, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0959, A));
    vecs.push_back(mkVec(0,0,0,0,1, 8'h00,8'h00, 16'h0959, D));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h01,8'h00, 16'h0100, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0100, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0059, A));
    vecs.push_back(mkVec(0,0,0,0,1, 8'h00,8'h00, 16'h0059, D));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h05, 16'h0005, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0005, A));
    vecs.push_back(mkVec(1,0,0,1,0, 8'h00,8'h00, 16'h0005, N));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0005, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0005, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0004, A));
    vecs.push_back(mkVec(0,0,1,1,0, 8'h00,8'h00, 16'h0004, N));
    vecs.push_back(mkVec(0,0,1,1,0, 8'h00,8'h00, 16'h0004, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0003, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0002, A));
    vecs.push_back(mkVec(1,0,0,0,1, 8'h00,8'h00, 16'h0002, D));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0002, D));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0002, D));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h30, 16'h0030, N));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h6A, 16'h0030, R));
    vecs.push_back(mkVec(0,0,0,0,0, 8'h00,8'h00, 16'h0030, N));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h00, 16'h0000, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0000, N));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h9A,8'h00, 16'h0000, R));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h10, 16'h0010, N));
    vecs.push_back(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0010, A));
    vecs.push_back(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0009, A));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h6A, 16'h0009, A));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h00,8'h20, 16'h0009, A));
    vecs.push_back(mkVec(0,0,0,0,1, 8'h00,8'h00, 16'h0009, D));
    vecs.push_back(mkVec(0,1,0,0,0, 8'h99,8'h59, 16'h9959, N));

    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 16'h0500, N);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].expDig, vecs[i].expFlags);
    end

    // Reset in the middle of a count, then ticks while IDLE must not be banked.
    applyStimulus(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h9959, A));
    checkState("arm9959", 16'h9959, A);
    applyStimulus(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h9958, A));
    checkState("tick9958", 16'h9958, A);
    doReset();
    checkState("midreset", 16'h0500, N);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0500, N));
      checkState($sformatf("idletick%0d", i), 16'h0500, N);
    end
    applyStimulus(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0500, A));
    checkState("arm0500", 16'h0500, A);
    applyStimulus(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0459, A));
    checkState("tick0459", 16'h0459, A);

`ifdef BOMBA_ALERTA_EN
    begin
      logic [15:0] expDigs [6];
      logic        expAl   [6];
      expDigs = '{16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h0000};
      expAl   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      doReset();
      checkOutput("alerta reset", {31'h0, alerta}, 32'h0);
      applyStimulus(mkVec(0,1,0,0,0, 8'h00,8'h05, 16'h0005, N));
      applyStimulus(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0005, A));
      checkOutput("alerta armed", {31'h0, alerta}, 32'h0);
      for (int i = 0; i < 6; i++) begin
        applyStimulus(mkVec(1,0,0,0,0, 8'h00,8'h00, expDigs[i], N));
        checkOutput($sformatf("alerta tick%0d", i), {31'h0, alerta}, {31'h0, expAl[i]});
        checkOutput($sformatf("alerta digits%0d", i), {16'h0, min_d, min_u, sec_d, sec_u},
                    {16'h0, expDigs[i]});
      end
      applyStimulus(mkVec(0,1,0,0,0, 8'h00,8'h02, 16'h0002, N));
      applyStimulus(mkVec(0,0,1,0,0, 8'h00,8'h00, 16'h0002, A));
      applyStimulus(mkVec(1,0,0,0,0, 8'h00,8'h00, 16'h0001, A));
      checkOutput("alerta window", {31'h0, alerta}, 32'h1);
      doReset();
      checkOutput("alerta midreset", {31'h0, alerta}, 32'h0);
      checkState("alerta midreset", 16'h0500, N);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
